// File: rtl/pla_vec_port_if.sv
// pla_vec_port_if: stream bundle between a test/config sequencer and pla_vec_port.
//   Input stream  : in_valid/in_ready carrying in_vec (NI), in_exp (NO), in_chk.
//   Result stream : out_valid/out_ready carrying out_z (NO), out_mis.
//   master: sequencer side (offers vectors, consumes results).
//   slave : pla_vec_port side.
interface pla_vec_port_if #(
    parameter int unsigned NI = 17,
    parameter int unsigned NO = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [NI-1:0] in_vec;
    logic [NO-1:0] in_exp;
    logic          in_chk;
    logic          out_valid;
    logic          out_ready;
    logic [NO-1:0] out_z;
    logic          out_mis;

    modport master (
        output in_valid, in_vec, in_exp, in_chk, out_ready,
        input  in_ready, out_valid, out_z, out_mis
    );

    modport slave (
        input  in_valid, in_vec, in_exp, in_chk, out_ready,
        output in_ready, out_valid, out_z, out_mis
    );
endinterface

// File: rtl/pla_vec_port.sv
// pla_vec_port: sequential driver for a combinational PLA core.
//   Accepts a vector on the input stream, registers it onto pla_x, waits SETTLE
//   cycles, captures pla_z (and an optional compare against the expected word)
//   and offers the result on the output stream until it is taken.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (slave)           input/result valid-ready streams
//   pla_x  [NI-1:0]       registered drive to the PLA inputs
//   pla_z  [NO-1:0]       PLA outputs (combinational from pla_x)
//   clr                   synchronous clear of counters and err_sticky
//   vec_count, err_count  saturating completed / mismatched vector counts
//   err_sticky            set on any mismatch until clr or reset
// SETTLE must be in 0..15 (4-bit settle counter).
module pla_vec_port #(
    parameter int unsigned NI     = 17,
    parameter int unsigned NO     = 16,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pla_vec_port_if.slave    bus,
    output logic [NI-1:0]    pla_x,
    input  logic [NO-1:0]    pla_z,
    input  logic             clr,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NI-1:0]    pla_x_q, pla_x_d;
    logic [NO-1:0]    exp_q, exp_d;
    logic             chk_q, chk_d;
    logic [NO-1:0]    out_z_q, out_z_d;
    logic             out_mis_q, out_mis_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_sticky_q, err_sticky_d;

    logic             capture;
    logic             mis_now;

    assign mis_now = chk_q & (pla_z != exp_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pla_x_d      = pla_x_q;
        exp_d        = exp_q;
        chk_d        = chk_q;
        out_z_d      = out_z_q;
        out_mis_d    = out_mis_q;
        vec_count_d  = vec_count_q;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        capture      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    pla_x_d = bus.in_vec;
                    exp_d   = bus.in_exp;
                    chk_d   = bus.in_chk;
                    cnt_d   = SettleCnt;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    capture   = 1'b1;
                    out_z_d   = pla_z;
                    out_mis_d = mis_now;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // clr wins over a same-cycle capture; the result word still captures above.
        if (clr) begin
            vec_count_d  = '0;
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else if (capture) begin
            if (!(&vec_count_q)) begin
                vec_count_d = vec_count_q + CNT_W'(1);
            end
            if (mis_now) begin
                err_sticky_d = 1'b1;
                if (!(&err_count_q)) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            pla_x_q      <= '0;
            exp_q        <= '0;
            chk_q        <= 1'b0;
            out_z_q      <= '0;
            out_mis_q    <= 1'b0;
            vec_count_q  <= '0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pla_x_q      <= pla_x_d;
            exp_q        <= exp_d;
            chk_q        <= chk_d;
            out_z_q      <= out_z_d;
            out_mis_q    <= out_mis_d;
            vec_count_q  <= vec_count_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Handshake outputs depend on the state register only.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_z     = out_z_q;
    assign bus.out_mis   = out_mis_q;
    assign pla_x         = pla_x_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_pla_vec_port.sv
// tb_pla_vec_port: self-checking bench for pla_vec_port.
//   Instance a: SETTLE=2, CNT_W=3, checked every cycle against a transaction-level
//   model plus directed literal checks. Instance b: SETTLE=0 latency check.
module tb_pla_vec_port;

    localparam int NI       = 17;
    localparam int NO       = 16;
    localparam int SETTLE_A = 2;
    localparam int CNT_A    = 3;
    localparam int CNT_MAX  = (1 << CNT_A) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance a ----------------
    pla_vec_port_if #(.NI(NI), .NO(NO)) a_if ();
    logic [NI-1:0]    a_pla_x;
    logic [NO-1:0]    a_pla_z;
    logic             a_clr;
    logic [CNT_A-1:0] a_vec_count, a_err_count;
    logic             a_err_sticky;

    assign a_pla_z = ~a_pla_x[15:0];

    pla_vec_port #(.NI(NI), .NO(NO), .SETTLE(SETTLE_A), .CNT_W(CNT_A)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (a_if),
        .pla_x      (a_pla_x),
        .pla_z      (a_pla_z),
        .clr        (a_clr),
        .vec_count  (a_vec_count),
        .err_count  (a_err_count),
        .err_sticky (a_err_sticky)
    );

    // ---------------- instance b ----------------
    pla_vec_port_if #(.NI(NI), .NO(NO)) b_if ();
    logic [NI-1:0] b_pla_x;
    logic [NO-1:0] b_pla_z;
    logic          b_clr;
    logic [15:0]   b_vec_count, b_err_count;
    logic          b_err_sticky;

    assign b_pla_z = ~b_pla_x[15:0];

    pla_vec_port #(.NI(NI), .NO(NO), .SETTLE(0), .CNT_W(16)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (b_if),
        .pla_x      (b_pla_x),
        .pla_z      (b_pla_z),
        .clr        (b_clr),
        .vec_count  (b_vec_count),
        .err_count  (b_err_count),
        .err_sticky (b_err_sticky)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] pla_fn(input logic [NI-1:0] x);
        return ~x[15:0];
    endfunction

    // ---------------- transaction-level model of instance a ----------------
    // A vector accepted at edge index t is captured at edge t+SETTLE+1; the result
    // is held until an edge with out_ready, after which a new vector may be taken.
    int            m_cyc, m_cap_at;
    bit            m_busy, m_hold, m_chk, m_mis;
    logic [NI-1:0] m_x;
    logic [NO-1:0] m_exp, m_z;
    int            m_vec, m_err;
    bit            m_sticky;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_cap_at = 0; m_busy = 0; m_hold = 0; m_chk = 0; m_mis = 0;
            m_x = '0; m_exp = '0; m_z = '0; m_vec = 0; m_err = 0; m_sticky = 0;
        end else begin
            bit cap;
            cap = 0;
            m_cyc++;
            if (!m_busy && !m_hold) begin
                if (a_if.in_valid) begin
                    m_x      = a_if.in_vec;
                    m_exp    = a_if.in_exp;
                    m_chk    = a_if.in_chk;
                    m_cap_at = m_cyc + SETTLE_A + 1;
                    m_busy   = 1;
                end
            end else if (m_busy) begin
                if (m_cyc == m_cap_at) begin
                    cap    = 1;
                    m_z    = pla_fn(m_x);
                    m_mis  = m_chk && (m_z != m_exp);
                    m_busy = 0;
                    m_hold = 1;
                end
            end else if (a_if.out_ready) begin
                m_hold = 0;
            end
            if (a_clr) begin
                m_vec = 0; m_err = 0; m_sticky = 0;
            end else if (cap) begin
                m_vec = (m_vec < CNT_MAX) ? m_vec + 1 : CNT_MAX;
                if (m_mis) begin
                    m_err    = (m_err < CNT_MAX) ? m_err + 1 : CNT_MAX;
                    m_sticky = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready",   a_if.in_ready,  !(m_busy || m_hold));
            check("out_valid",  a_if.out_valid, m_hold);
            check("out_z",      a_if.out_z,     m_z);
            check("out_mis",    a_if.out_mis,   m_mis);
            check("pla_x",      a_pla_x,        m_x);
            check("vec_count",  a_vec_count,    m_vec);
            check("err_count",  a_err_count,    m_err);
            check("err_sticky", a_err_sticky,   m_sticky);
        end
    end

    // ---------------- directed helpers for instance a ----------------
    task automatic push(input logic [NI-1:0] vec, input logic [NO-1:0] expw, input logic chk);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!a_if.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready_wait", a_if.in_ready, 1'b1);
        a_if.in_valid = 1'b1;
        a_if.in_vec   = vec;
        a_if.in_exp   = expw;
        a_if.in_chk   = chk;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        a_if.in_vec   = NI'($urandom());
        a_if.in_exp   = NO'($urandom());
        a_if.in_chk   = 1'($urandom());
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!a_if.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_wait", a_if.out_valid, 1'b1);
    endtask

    task automatic release_out();
        a_if.out_ready = 1'b1;
        @(negedge clk);
        a_if.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] r;

        a_if.in_valid = 0; a_if.in_vec = '0; a_if.in_exp = '0; a_if.in_chk = 0;
        a_if.out_ready = 0; a_clr = 0;
        b_if.in_valid = 0; b_if.in_vec = '0; b_if.in_exp = '0; b_if.in_chk = 0;
        b_if.out_ready = 0; b_clr = 0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_in_ready",  a_if.in_ready,  1'b1);
        check("rst_out_valid", a_if.out_valid, 1'b0);
        check("rst_pla_x",     a_pla_x,        '0);
        check("rst_vec_count", a_vec_count,    '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", a_if.in_ready, 1'b1);
        check("rel_counts",   {a_vec_count, a_err_count, a_err_sticky}, '0);

        // Single matching vector, latency SETTLE+1, then backpressure
        push(17'h00A5A, 16'hF5A5, 1'b1);
        check("single_pla_x", a_pla_x, 17'h00A5A);
        wait_valid(lat);
        check("single_latency", lat, 3);
        check("single_out_z",   a_if.out_z,   16'hF5A5);
        check("model_out_z",    m_z,          16'hF5A5);
        check("single_out_mis", a_if.out_mis, 1'b0);
        check("single_vec",     a_vec_count,  1);
        check("single_err",     a_err_count,  0);
        repeat (6) begin
            @(negedge clk);
            check("bp_out_z",     a_if.out_z,     16'hF5A5);
            check("bp_in_ready",  a_if.in_ready,  1'b0);
            check("bp_out_valid", a_if.out_valid, 1'b1);
        end
        release_out();
        check("bp_release_in_ready", a_if.in_ready, 1'b1);

        // Mismatch, then a matching vector keeps the sticky flag
        push(17'h00A5A, 16'h0000, 1'b1);
        wait_valid(lat);
        check("mis_out_mis", a_if.out_mis,  1'b1);
        check("mis_err",     a_err_count,   1);
        check("mis_sticky",  a_err_sticky,  1'b1);
        check("model_err",   m_err,         1);
        release_out();
        push(17'h1FFFF, 16'h0000, 1'b1);
        wait_valid(lat);
        check("match_out_mis", a_if.out_mis, 1'b0);
        check("match_sticky",  a_err_sticky, 1'b1);
        check("match_err",     a_err_count,  1);
        release_out();

        // No compare when in_chk=0
        push(17'h00001, 16'h1234, 1'b0);
        wait_valid(lat);
        check("nochk_out_mis", a_if.out_mis, 1'b0);
        check("nochk_err",     a_err_count,  1);
        check("nochk_vec",     a_vec_count,  4);
        release_out();

        // Saturation at 3 bits
        repeat (9) begin
            push(17'h00A5A, 16'h0000, 1'b1);
            wait_valid(lat);
            release_out();
        end
        check("sat_vec", a_vec_count, 7);
        check("sat_err", a_err_count, 7);

        // clr on the capture edge (accept E0, capture E0+3)
        push(17'h10001, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        check("clr_out_valid", a_if.out_valid, 1'b1);
        check("clr_out_z",     a_if.out_z,     16'hFFFE);
        check("clr_out_mis",   a_if.out_mis,   1'b1);
        check("clr_vec",       a_vec_count,    0);
        check("clr_err",       a_err_count,    0);
        check("clr_sticky",    a_err_sticky,   1'b0);
        release_out();
        push(17'h00F0F, 16'hF0F0, 1'b1);
        wait_valid(lat);
        check("post_clr_vec", a_vec_count, 1);
        release_out();

        // Asynchronous reset mid-SETTLE, between clock edges
        push(17'h0BEEF, 16'h0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  a_if.in_ready,  1'b1);
        check("arst_out_valid", a_if.out_valid, 1'b0);
        check("arst_pla_x",     a_pla_x,        '0);
        check("arst_vec",       a_vec_count,    '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("arst_no_valid", a_if.out_valid, 1'b0);
            check("arst_no_count", a_vec_count,    0);
        end
        push(17'h00123, 16'hFEDC, 1'b1);
        wait_valid(lat);
        check("arst_next_lat",   lat,          3);
        check("arst_next_out_z", a_if.out_z,   16'hFEDC);
        check("arst_next_vec",   a_vec_count,  1);
        release_out();

        // Randomised traffic, checked by the model every cycle
        repeat (2500) begin
            @(negedge clk);
            r = $urandom();
            a_if.in_valid  = (r[1:0] != 2'b00);
            a_if.in_vec    = NI'($urandom());
            a_if.in_chk    = r[2];
            a_if.in_exp    = r[3] ? ~a_if.in_vec[15:0] : NO'($urandom());
            a_if.out_ready = r[4] | r[5];
            a_clr          = (r[12:8] == 5'd0);
        end
        @(negedge clk);
        a_if.in_valid = 0; a_clr = 0; a_if.out_ready = 1;
        repeat (8) @(negedge clk);
        a_if.out_ready = 0;

        // Instance b: SETTLE=0 gives a one-cycle latency
        b_if.in_valid = 1'b1;
        b_if.in_vec   = 17'h12345;
        b_if.in_exp   = 16'hDCBA;
        b_if.in_chk   = 1'b1;
        @(negedge clk);
        b_if.in_valid = 1'b0;
        check("b_in_ready_busy", b_if.in_ready, 1'b0);
        check("b_pla_x",         b_pla_x,       17'h12345);
        lat = 0;
        while (!b_if.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b_latency",   lat,            1);
        check("b_out_z",     b_if.out_z,     16'hDCBA);
        check("b_out_mis",   b_if.out_mis,   1'b0);
        check("b_vec_count", b_vec_count,    1);
        b_if.out_ready = 1'b1;
        @(negedge clk);
        b_if.out_ready = 1'b0;
        check("b_in_ready_after", b_if.in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
